// File: rtl/alarm_buzzer_driver_pkg.sv
// Shared types and constants for the alarm buzzer responder.
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int DEF_CLK_HZ      = 1000;
    localparam int DEF_TONE_HALF   = 2;
    localparam int DEF_BEEP_ON     = 250;
    localparam int DEF_BEEP_OFF    = 250;
    localparam int DEF_SNOOZE_SEC  = 300;
    localparam int DEF_TIMEOUT_SEC = 60;

    localparam int SEC_W = 10;

    // Counter width for a count of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_buzzer_driver_sec_tick.sv
// Restartable seconds divider: one-cycle tick every CLK_HZ cycles after restart.
module sec_tick
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = cnt_width(CLK_HZ);
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Not gated by restart: the FSM decides restarts from this tick.
    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/alarm_buzzer_driver.sv
// Buzzer responder: rings on alarm request, handles stop/snooze/timeout, acks the alarm.
// state  | meaning
// IDLE   | no request, silent
// RING   | request active, beeping, timeout running
// SNOOZE | silent, counting snooze seconds
// HOLD   | acked, silent until request drops
module alarm_buzzer_driver
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int TONE_HALF   = DEF_TONE_HALF,
    parameter int BEEP_ON     = DEF_BEEP_ON,
    parameter int BEEP_OFF    = DEF_BEEP_OFF,
    parameter int SNOOZE_SEC  = DEF_SNOOZE_SEC,
    parameter int TIMEOUT_SEC = DEF_TIMEOUT_SEC
) (
    input  logic clk,
    input  logic reset,
    input  logic timer_buzzer,
    input  logic stop,
    input  logic snooze,
    output logic buzzer,
    output logic ringing,
    output logic snoozing,
    output logic alarm_ack
);

    localparam int TW = cnt_width(TONE_HALF);
    localparam int BW = cnt_width(max2(BEEP_ON, BEEP_OFF));

    localparam logic [TW-1:0]    TONE_LOAD = TW'(TONE_HALF - 1);
    localparam logic [BW-1:0]    ON_LOAD   = BW'(BEEP_ON - 1);
    localparam logic [BW-1:0]    OFF_LOAD  = BW'(BEEP_OFF - 1);
    localparam logic [SEC_W-1:0] SNZ_LOAD  = SEC_W'(SNOOZE_SEC);
    localparam logic [SEC_W-1:0] TMO_LAST  = SEC_W'(TIMEOUT_SEC - 1);

    state_t            r_state;
    logic              r_stop_q;
    logic              r_snooze_q;
    logic [SEC_W-1:0]  r_ring_sec;
    logic [SEC_W-1:0]  r_snz_sec;
    logic [BW-1:0]     r_beep_cnt;
    logic              r_gate_on;
    logic [TW-1:0]     r_tone_cnt;
    logic              r_tone;
    logic              r_buzzer;
    logic              r_ringing;
    logic              r_snoozing;
    logic              r_ack;

    state_t            w_next_state;
    logic              w_ack;
    logic              w_stop_edge;
    logic              w_snooze_edge;
    logic              w_tick;
    logic              w_timeout;
    logic              w_snz_done;
    logic              w_enter_ring;
    logic              w_enter_snooze;
    logic              w_restart;

    assign w_stop_edge    = stop & ~r_stop_q;
    assign w_snooze_edge  = snooze & ~r_snooze_q;
    assign w_timeout      = w_tick && (r_ring_sec >= TMO_LAST);
    assign w_snz_done     = w_tick && (r_snz_sec <= SEC_W'(1));
    assign w_enter_ring   = (w_next_state == ST_RING) && (r_state != ST_RING);
    assign w_enter_snooze = (w_next_state == ST_SNOOZE) && (r_state != ST_SNOOZE);
    assign w_restart      = w_enter_ring | w_enter_snooze;

    sec_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        w_ack        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (timer_buzzer) w_next_state = ST_RING;
            end
            ST_RING: begin
                if (w_stop_edge || w_timeout) begin
                    w_next_state = ST_HOLD;
                    w_ack        = 1'b1;
                end else if (w_snooze_edge) begin
                    w_next_state = ST_SNOOZE;
                end else if (!timer_buzzer) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SNOOZE: begin
                if (w_stop_edge) begin
                    w_next_state = ST_HOLD;
                    w_ack        = 1'b1;
                end else if (!timer_buzzer) begin
                    w_next_state = ST_IDLE;
                end else if (w_snz_done) begin
                    w_next_state = ST_RING;
                end
            end
            ST_HOLD: begin
                if (!timer_buzzer) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_stop_q   <= 1'b0;
            r_snooze_q <= 1'b0;
            r_ring_sec <= '0;
            r_snz_sec  <= '0;
            r_beep_cnt <= '0;
            r_gate_on  <= 1'b0;
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
            r_buzzer   <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_stop_q   <= stop;
            r_snooze_q <= snooze;
            r_state    <= w_next_state;
            r_ringing  <= (w_next_state == ST_RING);
            r_snoozing <= (w_next_state == ST_SNOOZE);
            r_ack      <= w_ack;

            if (w_enter_ring) begin
                r_ring_sec <= '0;
            end else if (r_state == ST_RING && w_tick && r_ring_sec != '1) begin
                r_ring_sec <= r_ring_sec + SEC_W'(1);
            end

            if (w_enter_snooze) begin
                r_snz_sec <= SNZ_LOAD;
            end else if (r_state == ST_SNOOZE && w_tick && r_snz_sec != '0) begin
                r_snz_sec <= r_snz_sec - SEC_W'(1);
            end

            // Beep gate and tone: down-counters; buzzer registered from next values.
            if (w_next_state != ST_RING) begin
                r_buzzer <= 1'b0;
            end else if (w_enter_ring) begin
                r_gate_on  <= 1'b1;
                r_beep_cnt <= ON_LOAD;
                r_tone     <= 1'b1;
                r_tone_cnt <= TONE_LOAD;
                r_buzzer   <= 1'b1;
            end else if (r_beep_cnt == '0) begin
                if (r_gate_on) begin
                    r_gate_on  <= 1'b0;
                    r_beep_cnt <= OFF_LOAD;
                    r_buzzer   <= 1'b0;
                end else begin
                    r_gate_on  <= 1'b1;
                    r_beep_cnt <= ON_LOAD;
                    r_tone     <= 1'b1;
                    r_tone_cnt <= TONE_LOAD;
                    r_buzzer   <= 1'b1;
                end
            end else begin
                r_beep_cnt <= r_beep_cnt - BW'(1);
                if (!r_gate_on) begin
                    r_buzzer <= 1'b0;
                end else if (r_tone_cnt == '0) begin
                    r_tone     <= ~r_tone;
                    r_tone_cnt <= TONE_LOAD;
                    r_buzzer   <= ~r_tone;
                end else begin
                    r_tone_cnt <= r_tone_cnt - TW'(1);
                    r_buzzer   <= r_tone;
                end
            end
        end
    end

    assign buzzer    = r_buzzer;
    assign ringing   = r_ringing;
    assign snoozing  = r_snoozing;
    assign alarm_ack = r_ack;

endmodule

// File: tb/tb_alarm_buzzer_driver.sv
// Scoreboard bench for alarm_buzzer_driver against a cycle-age reference model.
module tb_alarm_buzzer_driver;

    localparam int P_CLK_HZ  = 10;
    localparam int P_TONE    = 1;
    localparam int P_ON      = 4;
    localparam int P_OFF     = 2;
    localparam int P_SNZ     = 2;
    localparam int P_TMO     = 3;
    localparam int RING_CYC  = P_TMO * P_CLK_HZ;
    localparam int SNZ_CYC   = P_SNZ * P_CLK_HZ;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic timer_buzzer = 1'b0;
    logic stop = 1'b0;
    logic snooze = 1'b0;
    logic buzzer, ringing, snoozing, alarm_ack;

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    typedef enum int {M_IDLE, M_RING, M_SNZ, M_HOLD} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_age = 0;
    bit    m_prev_stop = 1'b0;
    bit    m_prev_snz = 1'b0;

    alarm_buzzer_driver #(
        .CLK_HZ      (P_CLK_HZ),
        .TONE_HALF   (P_TONE),
        .BEEP_ON     (P_ON),
        .BEEP_OFF    (P_OFF),
        .SNOOZE_SEC  (P_SNZ),
        .TIMEOUT_SEC (P_TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .timer_buzzer (timer_buzzer),
        .stop         (stop),
        .snooze       (snooze),
        .buzzer       (buzzer),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .alarm_ack    (alarm_ack)
    );

    always #5 clk = ~clk;

    function automatic bit beep_level(input int age);
        int p;
        p = age % (P_ON + P_OFF);
        return (p < P_ON) && (((p / P_TONE) % 2) == 0);
    endfunction

    // Advance the model across one clock edge; return {buzzer, ringing, snoozing, ack} after it.
    task automatic model_step(input bit rst, input bit req, input bit st, input bit sz,
                              output logic [3:0] e);
        bit se, ze, ack;
        se  = st && !m_prev_stop;
        ze  = sz && !m_prev_snz;
        ack = 1'b0;
        if (rst) begin
            m_mode = M_IDLE;
            m_age = 0;
            m_prev_stop = 1'b0;
            m_prev_snz = 1'b0;
            e = 4'b0000;
            return;
        end
        case (m_mode)
            M_IDLE: if (req) begin m_mode = M_RING; m_age = 0; end
            M_RING: begin
                if (se || m_age + 1 == RING_CYC) begin m_mode = M_HOLD; ack = 1'b1; end
                else if (ze)   begin m_mode = M_SNZ; m_age = 0; end
                else if (!req) m_mode = M_IDLE;
                else           m_age++;
            end
            M_SNZ: begin
                if (se)                        begin m_mode = M_HOLD; ack = 1'b1; end
                else if (!req)                 m_mode = M_IDLE;
                else if (m_age + 1 == SNZ_CYC) begin m_mode = M_RING; m_age = 0; end
                else                           m_age++;
            end
            M_HOLD: if (!req) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        m_prev_stop = st;
        m_prev_snz  = sz;
        e = {(m_mode == M_RING) && beep_level(m_age), m_mode == M_RING, m_mode == M_SNZ, ack};
    endtask

    task automatic step(input bit rst, input bit req, input bit st, input bit sz);
        logic [3:0] e;
        @(negedge clk);
        reset = rst;
        timer_buzzer = req;
        stop = st;
        snooze = sz;
        model_step(rst, req, st, sz, e);
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n, input bit rst, input bit req, input bit st, input bit sz);
        for (int i = 0; i < n; i++) step(rst, req, st, sz);
    endtask

    initial begin : monitor
        logic [3:0] e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {buzzer, ringing, snoozing, alarm_ack};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL outputs check=%0d t=%0t buz/ring/snz/ack got=%b exp=%b",
                             checks, $time, g, e);
                end
            end
        end
    end

    initial begin : stimulus
        bit r_req, r_st, r_sz, r_rst;
        hold(3, 1, 0, 0, 0);
        hold(2, 0, 0, 0, 0);
        // ring then stop, drop request
        hold(14, 0, 1, 0, 0);
        hold(2, 0, 1, 1, 0);
        hold(3, 0, 1, 0, 0);
        hold(3, 0, 0, 0, 0);
        // snooze, return to ring, snooze again, ignored snooze, stop in snooze
        hold(5, 0, 1, 0, 0);
        hold(1, 0, 1, 0, 1);
        hold(26, 0, 1, 0, 0);
        hold(1, 0, 1, 0, 1);
        hold(3, 0, 1, 0, 0);
        hold(1, 0, 1, 0, 1);
        hold(2, 0, 1, 0, 0);
        hold(1, 0, 1, 1, 0);
        hold(3, 0, 1, 0, 0);
        hold(2, 0, 0, 0, 0);
        // timeout with request held
        hold(45, 0, 1, 0, 0);
        hold(2, 0, 0, 0, 0);
        // simultaneous buttons
        hold(3, 0, 1, 0, 0);
        hold(1, 0, 1, 1, 1);
        hold(3, 0, 1, 0, 0);
        hold(2, 0, 0, 0, 0);
        // stop held across ring entry
        hold(2, 0, 0, 1, 0);
        hold(8, 0, 1, 1, 0);
        hold(2, 0, 1, 0, 0);
        hold(1, 0, 1, 1, 0);
        hold(2, 0, 1, 0, 0);
        hold(2, 0, 0, 0, 0);
        // external disarm in ring and in snooze
        hold(7, 0, 1, 0, 0);
        hold(3, 0, 0, 0, 0);
        hold(4, 0, 1, 0, 0);
        hold(1, 0, 1, 0, 1);
        hold(6, 0, 1, 0, 0);
        hold(3, 0, 0, 0, 0);
        // reset mid-ring and mid-snooze, request high right after
        hold(5, 0, 1, 0, 0);
        hold(1, 1, 1, 0, 0);
        hold(6, 0, 1, 0, 0);
        hold(1, 0, 1, 0, 1);
        hold(5, 0, 1, 0, 0);
        hold(1, 1, 1, 0, 0);
        hold(9, 0, 1, 0, 0);
        hold(3, 0, 0, 0, 0);
        // randomized traffic
        r_req = 1'b0; r_st = 1'b0; r_sz = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 79) == 0) r_req = !r_req;
            if ($urandom_range(0, 19) == 0) r_st = !r_st;
            if ($urandom_range(0, 14) == 0) r_sz = !r_sz;
            r_rst = ($urandom_range(0, 399) == 0);
            step(r_rst, r_req, r_st, r_sz);
        end
        hold(2, 0, 0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
